// File: rtl/phy_tx_sched.sv
// phy_tx_sched: brings a two-lane PHY link up through a fixed-length training
// phase, then merges two byte sources onto the lanes round-robin. All lane
// outputs and the enable are registered; tx_count totals bytes sent since reset.
module phy_tx_sched #(
  parameter int unsigned TRAIN_CYCLES = 4,
  parameter logic [7:0]  IDLE_SYM     = 8'hBC
) (
  input  logic        clk_f,
  input  logic        reset_L,
  input  logic        link_en,
  input  logic [7:0]  src_data_a,
  input  logic [7:0]  src_data_b,
  input  logic        src_valid_a,
  input  logic        src_valid_b,
  output logic        src_ready_a,
  output logic        src_ready_b,
  output logic [7:0]  phy_data_0,
  output logic [7:0]  phy_data_1,
  output logic        phy_valid_0,
  output logic        phy_valid_1,
  output logic        phy_enable,
  output logic [1:0]  link_state,
  output logic [15:0] tx_count
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_TRAIN  = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  localparam logic [7:0] TRAIN_LOAD = 8'(TRAIN_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  train_cnt;
  logic        rr_ptr;
  logic        ready;
  logic        xfer_a;
  logic        xfer_b;

  logic [7:0]  d0_nxt;
  logic [7:0]  d1_nxt;
  logic        v0_nxt;
  logic        v1_nxt;
  logic        en_nxt;
  logic        rr_nxt;

  // Sources are accepted only while the link is active and still requested.
  assign ready       = (state == ST_ACTIVE) && link_en;
  assign src_ready_a = ready;
  assign src_ready_b = ready;
  assign xfer_a      = src_valid_a && ready;
  assign xfer_b      = src_valid_b && ready;
  assign link_state  = state;

  // Next-state selection; a dropped link_en beats every other transition.
  always_comb begin
    state_nxt = ST_OFF;
    case (state)
      ST_OFF:    state_nxt = link_en ? ST_TRAIN : ST_OFF;
      ST_TRAIN:  begin
        if (!link_en)             state_nxt = ST_OFF;
        else if (train_cnt == '0) state_nxt = ST_ACTIVE;
        else                      state_nxt = ST_TRAIN;
      end
      ST_ACTIVE: state_nxt = link_en ? ST_ACTIVE : ST_OFF;
      default:   state_nxt = ST_OFF;
    endcase
  end

  // Lane contents and round-robin pointer for the coming cycle, derived from
  // the next state so outputs always agree with link_state after the edge.
  always_comb begin
    d0_nxt = '0;
    d1_nxt = '0;
    v0_nxt = 1'b0;
    v1_nxt = 1'b0;
    en_nxt = 1'b0;
    rr_nxt = rr_ptr;
    case (state_nxt)
      ST_TRAIN: begin
        d0_nxt = IDLE_SYM;
        d1_nxt = IDLE_SYM;
        en_nxt = 1'b1;
      end
      ST_ACTIVE: begin
        d0_nxt = IDLE_SYM;
        d1_nxt = IDLE_SYM;
        en_nxt = 1'b1;
        if (xfer_a && xfer_b) begin
          d0_nxt = rr_ptr ? src_data_b : src_data_a;
          d1_nxt = rr_ptr ? src_data_a : src_data_b;
          v0_nxt = 1'b1;
          v1_nxt = 1'b1;
          rr_nxt = ~rr_ptr;
        end else if (xfer_a) begin
          d0_nxt = src_data_a;
          v0_nxt = 1'b1;
          rr_nxt = 1'b1;
        end else if (xfer_b) begin
          d0_nxt = src_data_b;
          v0_nxt = 1'b1;
          rr_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Link FSM with registered lane outputs, training counter and byte tally.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= ST_OFF;
      train_cnt   <= '0;
      rr_ptr      <= 1'b0;
      tx_count    <= '0;
      phy_data_0  <= '0;
      phy_data_1  <= '0;
      phy_valid_0 <= 1'b0;
      phy_valid_1 <= 1'b0;
      phy_enable  <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      tx_count    <= tx_count + 16'(xfer_a) + 16'(xfer_b);
      phy_data_0  <= d0_nxt;
      phy_data_1  <= d1_nxt;
      phy_valid_0 <= v0_nxt;
      phy_valid_1 <= v1_nxt;
      phy_enable  <= en_nxt;
      if (state != ST_TRAIN && state_nxt == ST_TRAIN)
        train_cnt <= TRAIN_LOAD;
      else if (state == ST_TRAIN && train_cnt != '0)
        train_cnt <= train_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed bench for phy_tx_sched: a vector table for bring-up, scheduling and
// link drop, plus hand sequences for async reset and tx_count wrap.
module tb_phy_tx_sched;

  logic        clk_f = 1'b0;
  logic        reset_L;
  logic        link_en;
  logic [7:0]  src_data_a, src_data_b;
  logic        src_valid_a, src_valid_b;
  logic        src_ready_a, src_ready_b;
  logic [7:0]  phy_data_0, phy_data_1;
  logic        phy_valid_0, phy_valid_1, phy_enable;
  logic [1:0]  link_state;
  logic [15:0] tx_count;

  int n_tests = 0;
  int n_fail  = 0;

  phy_tx_sched #(.TRAIN_CYCLES(4), .IDLE_SYM(8'hBC)) dut (
    .clk_f       (clk_f),
    .reset_L     (reset_L),
    .link_en     (link_en),
    .src_data_a  (src_data_a),
    .src_data_b  (src_data_b),
    .src_valid_a (src_valid_a),
    .src_valid_b (src_valid_b),
    .src_ready_a (src_ready_a),
    .src_ready_b (src_ready_b),
    .phy_data_0  (phy_data_0),
    .phy_data_1  (phy_data_1),
    .phy_valid_0 (phy_valid_0),
    .phy_valid_1 (phy_valid_1),
    .phy_enable  (phy_enable),
    .link_state  (link_state),
    .tx_count    (tx_count)
  );

  always #5 clk_f = ~clk_f;

  typedef struct {
    logic        en;
    logic        va;
    logic [7:0]  da;
    logic        vb;
    logic [7:0]  db;
    logic        rdy;
    logic [1:0]  st;
    logic [7:0]  d0;
    logic        v0;
    logic [7:0]  d1;
    logic        v1;
    logic        pe;
    logic [15:0] tx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic va, input logic [7:0] da,
                     input logic vb, input logic [7:0] db, input logic rdy,
                     input logic [1:0] st, input logic [7:0] d0, input logic v0,
                     input logic [7:0] d1, input logic v1, input logic pe,
                     input logic [15:0] tx);
    vec_t v;
    v.en = en; v.va = va; v.da = da; v.vb = vb; v.db = db; v.rdy = rdy;
    v.st = st; v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1; v.pe = pe; v.tx = tx;
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st,
                          input logic [7:0] d0, input logic v0,
                          input logic [7:0] d1, input logic v1,
                          input logic pe, input logic [15:0] tx);
    chk({tag, ".state"}, 32'(link_state), 32'(st));
    chk({tag, ".d0"},    32'(phy_data_0), 32'(d0));
    chk({tag, ".v0"},    32'(phy_valid_0), 32'(v0));
    chk({tag, ".d1"},    32'(phy_data_1), 32'(d1));
    chk({tag, ".v1"},    32'(phy_valid_1), 32'(v1));
    chk({tag, ".en"},    32'(phy_enable), 32'(pe));
    chk({tag, ".tx"},    32'(tx_count), 32'(tx));
  endtask

  task automatic drive(input logic en, input logic va, input logic [7:0] da,
                       input logic vb, input logic [7:0] db);
    link_en = en; src_valid_a = va; src_data_a = da;
    src_valid_b = vb; src_data_b = db;
  endtask

  initial begin
    reset_L = 1'b0;
    drive(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB);

    //   en va da    vb db    rdy st     d0    v0 d1    v1 pe tx
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd0);  // 0 OFF->TRAIN
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd0);  // 4th TRAIN cycle
    add(1, 1, 8'h99, 0, 8'h00, 0, 2'b10, 8'hBC, 0, 8'hBC, 0, 1, 16'd0);  // 4 ->ACTIVE, no xfer
    add(1, 1, 8'h11, 1, 8'h33, 1, 2'b10, 8'h11, 1, 8'h33, 1, 1, 16'd2);  // rr0
    add(1, 1, 8'h22, 1, 8'h44, 1, 2'b10, 8'h44, 1, 8'h22, 1, 1, 16'd4);  // rr1
    add(1, 1, 8'h5A, 0, 8'h00, 1, 2'b10, 8'h5A, 1, 8'hBC, 0, 1, 16'd5);  // A only -> rr1
    add(1, 1, 8'h66, 0, 8'h00, 1, 2'b10, 8'h66, 1, 8'hBC, 0, 1, 16'd6);  // A only, rr stays 1
    add(1, 1, 8'h77, 1, 8'h88, 1, 2'b10, 8'h88, 1, 8'h77, 1, 1, 16'd8);  // rr1 -> B first
    add(1, 0, 8'h00, 1, 8'h99, 1, 2'b10, 8'h99, 1, 8'hBC, 0, 1, 16'd9);  // B only -> rr0
    add(1, 1, 8'hAA, 1, 8'hBB, 1, 2'b10, 8'hAA, 1, 8'hBB, 1, 1, 16'd11); // rr0 -> rr1
    add(1, 0, 8'h00, 0, 8'h00, 1, 2'b10, 8'hBC, 0, 8'hBC, 0, 1, 16'd11); // idle, rr held 1
    add(1, 1, 8'h03, 0, 8'h00, 1, 2'b10, 8'h03, 1, 8'hBC, 0, 1, 16'd12); // rr1
    add(0, 1, 8'h55, 1, 8'h56, 0, 2'b00, 8'h00, 0, 8'h00, 0, 0, 16'd12); // 14 link drop
    add(0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 0, 8'h00, 0, 0, 16'd12);
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd12); // 16 TRAIN
    add(0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 0, 8'h00, 0, 0, 16'd12); // 17 drop mid-TRAIN
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd12); // 18 counter reloaded
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd12);
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd12);
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 8'hBC, 0, 8'hBC, 0, 1, 16'd12);
    add(1, 0, 8'h00, 0, 8'h00, 0, 2'b10, 8'hBC, 0, 8'hBC, 0, 1, 16'd12); // 22 ACTIVE
    add(1, 1, 8'hC1, 1, 8'hC2, 1, 2'b10, 8'hC2, 1, 8'hC1, 1, 1, 16'd14); // rr=1 kept over OFF
    add(1, 0, 8'h00, 1, 8'hD4, 1, 2'b10, 8'hD4, 1, 8'hBC, 0, 1, 16'd15);
    add(1, 1, 8'hE1, 1, 8'hE2, 1, 2'b10, 8'hE1, 1, 8'hE2, 1, 1, 16'd17);

    // Reset state, with the clock running and inputs active.
    #1;
    chk_outs("rst0", 2'b00, 8'h00, 0, 8'h00, 0, 0, 16'd0);
    chk("rst0.rdy_a", 32'(src_ready_a), 32'd0);
    chk("rst0.rdy_b", 32'(src_ready_b), 32'd0);
    repeat (2) @(posedge clk_f);
    #1;
    chk_outs("rst1", 2'b00, 8'h00, 0, 8'h00, 0, 0, 16'd0);

    @(negedge clk_f);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    reset_L = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_f);
      drive(vecs[i].en, vecs[i].va, vecs[i].da, vecs[i].vb, vecs[i].db);
      #1;
      chk($sformatf("v%0d.rdy_a", i), 32'(src_ready_a), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.rdy_b", i), 32'(src_ready_b), 32'(vecs[i].rdy));
      @(posedge clk_f);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].st, vecs[i].d0, vecs[i].v0,
               vecs[i].d1, vecs[i].v1, vecs[i].pe, vecs[i].tx);
    end

    // Asynchronous reset between edges while ACTIVE with traffic offered.
    @(negedge clk_f);
    drive(1'b1, 1'b1, 8'h71, 1'b1, 8'h72);
    #2 reset_L = 1'b0;
    #1;
    chk_outs("arst", 2'b00, 8'h00, 0, 8'h00, 0, 0, 16'd0);
    chk("arst.rdy_a", 32'(src_ready_a), 32'd0);
    chk("arst.rdy_b", 32'(src_ready_b), 32'd0);
    @(posedge clk_f);
    #1;
    chk("arst_hold.state", 32'(link_state), 32'd0);
    @(negedge clk_f);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    reset_L = 1'b1;
    #1;
    chk("arst_rel.state", 32'(link_state), 32'd0);
    @(posedge clk_f);
    #1;
    chk("arst_rel.train", 32'(link_state), 32'd1);
    repeat (4) @(posedge clk_f);
    #1;
    chk("wrap_up.state", 32'(link_state), 32'd2);
    chk("wrap_up.tx", 32'(tx_count), 32'd0);

    // Drive tx_count to 0xFFFF, then one dual transfer wraps to 0x0001.
    drive(1'b1, 1'b1, 8'h01, 1'b1, 8'h02);
    repeat (32767) @(posedge clk_f);
    #1;
    chk("wrap.fffe", 32'(tx_count), 32'h0000_FFFE);
    drive(1'b1, 1'b1, 8'h12, 1'b0, 8'h00);
    @(posedge clk_f);
    #1;
    chk("wrap.ffff", 32'(tx_count), 32'h0000_FFFF);
    drive(1'b1, 1'b1, 8'h12, 1'b1, 8'h34);
    @(posedge clk_f);
    #1;
    chk_outs("wrap", 2'b10, 8'h34, 1, 8'h12, 1, 1, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
